// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Bundles the EX-stage request and the stall/result handshake of the RV32M
// multiply/divide unit.
//   start_i      M-extension instruction valid in EX (held while stall_o=1)
//   funct3_i     operation select (MUL..REMU)
//   operand_a_i  rs1 after the forwarding mux
//   operand_b_i  rs2 after the forwarding mux
//   flush_i      squash the in-flight operation
//   stall_o      freeze PC, IF/ID and ID/EX
//   done_o       result_o valid this cycle
//   result_o     registered result
// The master modport is the pipeline side; the slave modport is the unit.
interface muldiv_unit_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, funct3_i, operand_a_i, operand_b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, operand_a_i, operand_b_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle RV32M multiply/divide unit sitting in EX. Multiplies take a
// fixed two cycles; divides use a 32-step radix-2 restoring divider on the
// operand magnitudes, with divide-by-zero and signed overflow resolved in a
// single cycle. The pipeline is held with stall_o until the result is ready.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    muldiv_unit_if.slave: start/funct3/operands/flush in,
//          stall/done/result out
module muldiv_unit (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [1:0]  r_opSel;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [5:0]  r_cnt;
  logic        r_negQuot;
  logic        r_negRem;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_signedDiv;
  logic        w_divZero;
  logic        w_overflow;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_specialResult;
  logic [32:0] w_mulA;
  logic [32:0] w_mulB;
  logic [63:0] w_product;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_remNext;
  logic [31:0] w_quotNext;
  logic [31:0] w_divResult;

  // Request decode while idle. Odd funct3 codes are the unsigned divides.
  assign w_accept    = (r_state == IDLE) && bus.start_i && !bus.flush_i;
  assign w_signedDiv = !bus.funct3_i[0];
  assign w_divZero   = (bus.operand_b_i == 32'd0);
  assign w_overflow  = w_signedDiv && (bus.operand_a_i == 32'h8000_0000) &&
                       (bus.operand_b_i == 32'hFFFF_FFFF);
  assign w_absA = (w_signedDiv && bus.operand_a_i[31]) ? -bus.operand_a_i : bus.operand_a_i;
  assign w_absB = (w_signedDiv && bus.operand_b_i[31]) ? -bus.operand_b_i : bus.operand_b_i;

  // funct3[1] selects the remainder flavour of each special case.
  assign w_specialResult = w_divZero ? (bus.funct3_i[1] ? bus.operand_a_i : 32'hFFFF_FFFF)
                                     : (bus.funct3_i[1] ? 32'd0 : 32'h8000_0000);

  // 33-bit extension: a is signed for all but MULHU, b only for MUL/MULH.
  // Sign-extending to 64 bits keeps the low 64 product bits exact.
  assign w_mulA    = {(r_opSel != 2'b11) && r_opA[31], r_opA};
  assign w_mulB    = {!r_opSel[1] && r_opB[31], r_opB};
  assign w_product = {{31{w_mulA[32]}}, w_mulA} * {{31{w_mulB[32]}}, w_mulB};

  // Restoring step. The shifted partial remainder can exceed 32 bits for
  // large unsigned divisors, so the compare keeps the carried-out bit; the
  // subtraction itself fits in 32 bits whenever it is taken.
  assign w_shift     = {r_rem, r_quot[31]};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_remNext   = w_ge ? (w_shift[31:0] - r_divisor) : w_shift[31:0];
  assign w_quotNext  = {r_quot[30:0], w_ge};
  assign w_divResult = r_opSel[1] ? (r_negRem  ? -w_remNext  : w_remNext)
                                  : (r_negQuot ? -w_quotNext : w_quotNext);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!bus.funct3_i[2])            w_nextState = MUL;
          else if (w_divZero || w_overflow) w_nextState = DONE;
          else                              w_nextState = DIV;
        end
      end
      MUL:  w_nextState = DONE;
      DIV:  if (r_cnt == 6'd1) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (bus.flush_i) w_nextState = IDLE;
  end

  // Datapath. Every result write is gated by flush so a squashed operation
  // leaves result_o untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opSel   <= 2'b00;
      r_opA     <= 32'd0;
      r_opB     <= 32'd0;
      r_quot    <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_cnt     <= 6'd0;
      r_negQuot <= 1'b0;
      r_negRem  <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opSel   <= bus.funct3_i[1:0];
            r_opA     <= bus.operand_a_i;
            r_opB     <= bus.operand_b_i;
            r_quot    <= w_absA;
            r_rem     <= 32'd0;
            r_divisor <= w_absB;
            r_cnt     <= 6'd32;
            r_negQuot <= w_signedDiv && (bus.operand_a_i[31] ^ bus.operand_b_i[31]);
            r_negRem  <= w_signedDiv && bus.operand_a_i[31];
            if (bus.funct3_i[2] && (w_divZero || w_overflow))
              r_result <= w_specialResult;
          end
        end
        MUL: begin
          if (!bus.flush_i)
            r_result <= (r_opSel == 2'b00) ? w_product[31:0] : w_product[63:32];
        end
        DIV: begin
          if (!bus.flush_i) begin
            r_quot <= w_quotNext;
            r_rem  <= w_remNext;
            r_cnt  <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) r_result <= w_divResult;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o  = w_accept || (r_state == MUL) || (r_state == DIV);
  assign bus.done_o   = (r_state == DONE);
  assign bus.result_o = r_result;

endmodule
